// File: rtl/lpddr2_avl_memtest.sv
// Power-on Avalon-MM memory self-test for the LPDDR2 controller port:
// writes pat(a) = {5'b0,a}^SEED over a word range, reads it back in order, compares.
module lpddr2_avl_memtest #(
  parameter logic [26:0] START_ADDR      = 27'd0,
  parameter int          NUM_WORDS       = 1024,
  parameter logic [31:0] SEED            = 32'hA5A5_5A5A,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic        avl_waitrequest_n,
  output logic        avl_beginbursttransfer,
  output logic [26:0] avl_address,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  output logic        avl_read,
  output logic        avl_write,
  output logic        avl_burstcount,
  input  logic        local_init_done,
  input  logic        local_cal_success,
  input  logic        local_cal_fail,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        cal_error,
  output logic [15:0] err_count,
  output logic [26:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [27:0] LAST_IDX = 28'(NUM_WORDS - 1);
  localparam logic [27:0] N_WORDS  = 28'(NUM_WORDS);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

  function automatic logic [31:0] pat(input logic [26:0] a);
    return {5'b0, a} ^ SEED;
  endfunction

  state_t      state, state_n;
  logic [26:0] wr_addr, rd_addr, cmp_addr;
  logic [27:0] cmd_cnt, rsp_cnt;
  logic [3:0]  outstanding;
  logic        cmd_pend;
  logic        wr_en, rd_en, accept, last_cmd, rsp, start_ok, mismatch;

  assign avl_byteenable = 4'hF;
  assign avl_burstcount = 1'b1;

  assign accept   = (avl_read | avl_write) & avl_waitrequest_n;
  assign last_cmd = accept & (cmd_cnt == LAST_IDX);
  assign rsp      = avl_readdatavalid & ((state == READ) | (state == DRAIN));
  assign start_ok = start & ((state == IDLE) | (state == DONE));
  assign mismatch = avl_readdata != pat(cmp_addr);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n                = state;
    wr_en                  = 1'b0;
    rd_en                  = 1'b0;
    avl_write              = 1'b0;
    avl_read               = 1'b0;
    avl_address            = '0;
    avl_writedata          = '0;
    avl_beginbursttransfer = 1'b0;
    busy                   = 1'b0;
    done                   = 1'b0;
    case (state)
      IDLE: if (start) state_n = WAIT_CAL;
      WAIT_CAL: begin
        busy = 1'b1;
        if (local_cal_fail)                            state_n = DONE;
        else if (local_init_done && local_cal_success) state_n = WRITE;
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (last_cmd) state_n = READ;
      end
      READ: begin
        busy  = 1'b1;
        // Read is only presented when a slot is free; outstanding can only
        // shrink during a stall, so a presented read stays presented.
        rd_en = outstanding < MAX_OUT;
        if (last_cmd) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (outstanding == 4'd0 && rsp_cnt == N_WORDS) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = WAIT_CAL;
      end
      default: state_n = IDLE;
    endcase
    avl_write = wr_en;
    avl_read  = rd_en;
    if (wr_en) begin
      avl_address   = wr_addr;
      avl_writedata = pat(wr_addr);
    end else if (rd_en) begin
      avl_address = rd_addr;
    end
    avl_beginbursttransfer = (wr_en | rd_en) & ~cmd_pend;
  end

  assign pass = done & (err_count == 16'd0) & ~cal_error;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_addr        <= '0;
      rd_addr        <= '0;
      cmp_addr       <= '0;
      cmd_cnt        <= '0;
      rsp_cnt        <= '0;
      outstanding    <= '0;
      cmd_pend       <= 1'b0;
      cal_error      <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      // Presented but stalled: next cycle is a continuation, not a new command.
      cmd_pend <= (avl_read | avl_write) & ~avl_waitrequest_n;
      if (start_ok) begin
        cal_error      <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        cmd_cnt        <= '0;
        rsp_cnt        <= '0;
        outstanding    <= '0;
        cmp_addr       <= START_ADDR;
      end
      if (state == WAIT_CAL) begin
        wr_addr <= START_ADDR;
        if (local_cal_fail) cal_error <= 1'b1;
      end
      if (accept) begin
        cmd_cnt <= last_cmd ? 28'd0 : cmd_cnt + 28'd1;
        if (wr_en) wr_addr <= wr_addr + 27'd1;
        if (rd_en) rd_addr <= rd_addr + 27'd1;
      end
      if (state == WRITE && last_cmd) rd_addr <= START_ADDR;
      case ({accept & rd_en, rsp})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase
      if (rsp) begin
        rsp_cnt  <= rsp_cnt + 28'd1;
        cmp_addr <= cmp_addr + 27'd1;
        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0)    first_err_addr <= cmp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpddr2_avl_memtest.sv
// Randomized bench: behavioural Avalon slave with a word memory, in-order
// latency queue and random stalls; protocol and result checks.
module tb_lpddr2_avl_memtest;
  localparam logic [26:0] START = 27'h100;
  localparam int          NW    = 16;
  localparam logic [31:0] SEED  = 32'hA5A5_5A5A;
  localparam int          MAXO  = 2;

  logic        clk_clk = 1'b0, reset_reset = 1'b1, start = 1'b0;
  logic        avl_waitrequest_n = 1'b1, avl_readdatavalid = 1'b0;
  logic [31:0] avl_readdata = '0;
  logic        local_init_done = 1'b1, local_cal_success = 1'b1, local_cal_fail = 1'b0;
  logic        avl_beginbursttransfer, avl_read, avl_write, avl_burstcount;
  logic [26:0] avl_address, first_err_addr;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        busy, done, pass, cal_error;
  logic [15:0] err_count;

  lpddr2_avl_memtest #(.START_ADDR(START), .NUM_WORDS(NW), .SEED(SEED), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_beginbursttransfer(avl_beginbursttransfer),
    .avl_address(avl_address), .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable), .avl_read(avl_read),
    .avl_write(avl_write), .avl_burstcount(avl_burstcount), .local_init_done(local_init_done),
    .local_cal_success(local_cal_success), .local_cal_fail(local_cal_fail), .busy(busy),
    .done(done), .pass(pass), .cal_error(cal_error), .err_count(err_count),
    .first_err_addr(first_err_addr));

  always #5 clk_clk = ~clk_clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tpat(input int a);
    return 32'(a) ^ SEED;
  endfunction

  // slave model state
  logic [31:0] mem [int];
  int          due_q[$];
  logic [31:0] dat_q[$];
  int          cyc = 0, lat = 3, stall_pct = 0;
  bit          flip = 0, stalled = 0, any_cmd = 0;
  logic [60:0] prev_cmd = '0;
  int          nw = 0, nr = 0, nret = 0, merr = 0, mfirst = 0, peak = 0;

  initial begin
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (reset_reset) begin
        due_q.delete(); dat_q.delete();
        stalled = 0; avl_readdatavalid = 1'b0; avl_waitrequest_n = 1'b1;
        continue;
      end
      avl_waitrequest_n = ($urandom_range(99) >= stall_pct);
      avl_readdatavalid = 1'b0;
      avl_readdata      = '0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = dat_q[0];
        void'(due_q.pop_front()); void'(dat_q.pop_front());
        if (dat_q.size() >= 0 && avl_readdata != tpat(int'(START) + nret)) begin
          if (merr == 0) mfirst = int'(START) + nret;
          merr++;
        end
        nret++;
      end
      #1;
      if (avl_read | avl_write) begin
        any_cmd = 1;
        chk("bbt", avl_beginbursttransfer, !stalled);
        if (stalled) chk("hold", {avl_read, avl_write, avl_address, avl_writedata}, prev_cmd);
        chk("rw_excl", avl_read & avl_write, 1'b0);
        if (avl_waitrequest_n) begin
          if (avl_write) begin
            chk("wr_addr", avl_address, START + 27'(nw));
            chk("wr_data", avl_writedata, tpat(int'(START) + nw));
            mem[int'(avl_address)] = avl_writedata;
            nw++;
          end else begin
            chk("rd_addr", avl_address, START + 27'(nr));
            due_q.push_back(cyc + lat);
            dat_q.push_back((mem.exists(int'(avl_address)) ? mem[int'(avl_address)] : 32'h0) ^
                            {31'd0, flip && (avl_address == 27'h105 || avl_address == 27'h10A)});
            nr++;
          end
        end
      end else begin
        chk("bbt_idle", avl_beginbursttransfer, 1'b0);
      end
      if (nr - nret > peak) peak = nr - nret;
      chk("outst_le_max", (nr - nret) > MAXO, 1'b0);
      stalled  = (avl_read | avl_write) & ~avl_waitrequest_n;
      prev_cmd = {avl_read, avl_write, avl_address, avl_writedata};
    end
  end

  task automatic launch(input int l, input int s, input bit f);
    @(posedge clk_clk); #2;
    lat = l; stall_pct = s; flip = f;
    nw = 0; nr = 0; nret = 0; merr = 0; mfirst = 0; peak = 0; any_cmd = 0;
    start = 1'b1;
    @(posedge clk_clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 4000 && !done; i++) @(posedge clk_clk) #2;
    chk({tag, "_timeout"}, done, 1'b1);
  endtask

  task automatic check_result(input string tag);
    wait_done(tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_nw"}, 64'(nw), 64'(NW));
    chk({tag, "_nr"}, 64'(nr), 64'(NW));
    chk({tag, "_nret"}, 64'(nret), 64'(NW));
    chk({tag, "_errcnt"}, err_count, 64'(merr));
    chk({tag, "_first"}, first_err_addr, 64'(mfirst));
    chk({tag, "_pass"}, pass, merr == 0);
    chk({tag, "_calerr"}, cal_error, 1'b0);
  endtask

  initial begin
    int i;
    repeat (3) @(posedge clk_clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_cmd", {avl_read, avl_write, avl_beginbursttransfer}, 3'b000);
    chk("rst_be_bc", {avl_byteenable, avl_burstcount}, 5'h1F);
    chk("rst_err", {err_count, first_err_addr}, 43'd0);
    reset_reset = 1'b0;

    launch(3, 0, 0);          check_result("ideal");
    launch(3, 0, 1);          check_result("flip");
    chk("flip_errcnt_const", err_count, 16'd2);
    chk("flip_first_const", first_err_addr, 27'h105);
    launch(3, 50, 0);         check_result("stall");
    launch(10, 0, 0);         check_result("lat10");
    chk("lat10_peak", 64'(peak), 64'(MAXO));
    launch(1, 30, 0);         check_result("lat1");

    // calibration failure while waiting
    local_init_done = 1'b0; local_cal_success = 1'b0;
    launch(3, 0, 0);
    repeat (5) @(posedge clk_clk);
    #2;
    chk("cal_wait_busy", busy, 1'b1);
    local_cal_fail = 1'b1;
    wait_done("calfail");
    chk("calfail_err", cal_error, 1'b1);
    chk("calfail_pass", pass, 1'b0);
    chk("calfail_nocmd", any_cmd, 1'b0);
    local_cal_fail = 1'b0; local_init_done = 1'b1; local_cal_success = 1'b1;

    // reset while reads are in flight
    launch(3, 0, 0);
    for (i = 0; i < 2000 && !(avl_read && nr >= 3); i++) @(posedge clk_clk) #2;
    chk("mid_read_reached", avl_read, 1'b1);
    reset_reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_read", avl_read, 1'b0);
    repeat (3) @(posedge clk_clk);
    #2;
    reset_reset = 1'b0;
    launch(3, 20, 0);         check_result("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lpddr2_avl_memtest.md
Name: lpddr2_avl_memtest

Overview:
- Avalon-MM master that sits directly upstream of the LPDDR2 controller's `lpddr2_avl_0` slave port.
- After calibration it writes a deterministic pattern over a configurable word range, reads the range back, and compares each word.
- Reports pass/fail, a saturating error count and the first failing address.
- Serves as power-on memory self-test before the port is handed to user logic.

Parameters:
- START_ADDR, 0, first word address tested (27-bit word address).
- NUM_WORDS, 1024, number of words tested (>=1; START_ADDR+NUM_WORDS <= 2^27).
- SEED, 32'hA5A5_5A5A, XOR seed for the pattern.
- MAX_OUTSTANDING, 8, maximum in-flight reads (1..15).

Ports:
- clk_clk  in  1  controller user clock.
- reset_reset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse that begins a test.
- avl_waitrequest_n  in  1  slave ready; low = stall.
- avl_beginbursttransfer  out  1  first cycle of each command.
- avl_address  out  27  word address.
- avl_readdatavalid  in  1  read data valid.
- avl_readdata  in  32  read data.
- avl_writedata  out  32  write data.
- avl_byteenable  out  4  byte enables; always 4'hF.
- avl_read  out  1  read request.
- avl_write  out  1  write request.
- avl_burstcount  out  1  always 1.
- local_init_done  in  1  controller init done.
- local_cal_success  in  1  calibration succeeded.
- local_cal_fail  in  1  calibration failed.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start.
- pass  out  1  valid when done; 1 = no errors.
- cal_error  out  1  test aborted by calibration failure.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  27  address of first mismatch.

Behaviour:
- Clocking and reset: single clock domain `clk_clk`. Reset is asynchronous active-high on `reset_reset`.
- Reset values: all outputs 0 (`avl_byteenable` = 4'hF, `avl_burstcount` = 1); state IDLE; counters 0.
- Pattern: `pat(a) = {5'b0, a} ^ SEED`, where a = word address.
- Command handshake:
  - A command is accepted in the cycle where (`avl_read` | `avl_write`) & `avl_waitrequest_n`.
  - Address, data and controls are held stable while `avl_waitrequest_n` = 0.
  - `avl_beginbursttransfer` is high only in the first cycle a new command is presented, including when that cycle stalls.
  - Never assert `avl_read` and `avl_write` together.
- FSM:
  - IDLE: `start` -> clear `done`/`pass`/`cal_error`/`err_count`/`first_err_addr`, set `busy`, go to WAIT_CAL.
  - WAIT_CAL:
    - `local_cal_fail` = 1 -> DONE with `cal_error` = 1, `pass` = 0.
    - Otherwise, when `local_init_done` & `local_cal_success` -> WRITE with wr_addr = START_ADDR.
  - WRITE: present a write of `pat(wr_addr)`. On accept, wr_addr++. After NUM_WORDS accepts -> READ with rd_addr = START_ADDR.
  - READ:
    - Present a read while outstanding < MAX_OUTSTANDING. On accept, rd_addr++ and outstanding++.
    - When outstanding = MAX_OUTSTANDING, deassert `avl_read` (no new command).
    - After NUM_WORDS read accepts -> DRAIN.
  - DRAIN: wait until outstanding = 0 and all NUM_WORDS responses have been received -> DONE.
  - DONE: `busy` = 0, `done` = 1, `pass` = (`err_count` == 0) & ~`cal_error`. `start` -> restart as from IDLE.
- Read-return tracking:
  - Responses return in order. Compare counter `cmp_addr` starts at START_ADDR.
  - Each `avl_readdatavalid` in READ/DRAIN: outstanding--, compare `avl_readdata` against `pat(cmp_addr)`, then `cmp_addr`++.
  - Mismatch: `err_count`++ (saturating). If this is the first error, latch `cmp_addr` into `first_err_addr`.
  - Accept and return in the same cycle: outstanding unchanged.
  - `avl_readdatavalid` in any other state is ignored.
- `start` while `busy`: ignored.
- Address arithmetic: 27-bit; no wrap within a legal range.
- Reset mid-test: outputs drop immediately and FSM returns to IDLE. The controller shares this reset, so no stale responses are expected.

Test Plan:
- Ideal slave (`avl_waitrequest_n` = 1, readdata echoes memory model, 3-cycle read latency), NUM_WORDS = 16, START_ADDR = 0x100:
  - Exactly 16 writes with data `0x100^SEED` … `0x10F^SEED`, then 16 reads.
  - `done` = 1, `pass` = 1, `err_count` = 0.
- Memory model flips bit 0 at word 0x105 and 0x10A:
  - `err_count` = 2, `first_err_addr` = 0x105, `pass` = 0.
- Random `avl_waitrequest_n` stalls (50%):
  - Address/data stable during each stall.
  - `avl_beginbursttransfer` = 1 only on the first cycle of each command.
  - Result `pass` = 1.
- MAX_OUTSTANDING = 2, read latency 10 cycles:
  - Outstanding never exceeds 2.
  - A same-cycle accept and return keeps the count unchanged.
  - `pass` = 1.
- `local_cal_fail` = 1 during WAIT_CAL:
  - `done` = 1, `cal_error` = 1, `pass` = 0.
  - No `avl_read`/`avl_write` ever asserted.
- Assert `reset_reset` mid-READ:
  - `busy`/`avl_read` = 0 in the same cycle.
  - A subsequent `start` runs a full test to `pass` = 1.
